// File: rtl/led_ctrl_pkg.sv
// rtl/led_ctrl_pkg.sv - shared mode encoding for the LED mode controller
//
// Purpose: display mode codes used by led_ctrl and visible on its mode output.
// Ports:   none (package).
package led_ctrl_pkg;

  localparam int MODE_W = 3;

  // Codes 5..7 are never produced; the FSM maps them back to MODE_OFF.
  typedef enum logic [MODE_W-1:0] {
    MODE_OFF    = 3'd0,
    MODE_ON     = 3'd1,
    MODE_SLOW   = 3'd2,
    MODE_FAST   = 3'd3,
    MODE_BREATH = 3'd4
  } mode_e;

endpackage

// File: rtl/led_ctrl_key_debounce.sv
// rtl/led_ctrl_key_debounce.sv - key synchronizer, debounce filter and press pulse
//
// Purpose: brings the raw active-low key into the clock domain, accepts a level
//          change only after DEBOUNCE_CYC consecutive cycles of disagreement
//          with the accepted level, and pulses key_press on an accepted press.
// Ports:   clk       system clock
//          rst_n     asynchronous active-low reset
//          key       raw push-button, active-low, asynchronous
//          key_press one-cycle pulse when the accepted level goes 1->0
module key_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic key_press
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]    key_sync;
  logic          key_stable;
  logic [CW-1:0] cnt;

  // Synchronizer and stable level reset to the idle (released) level, so a key
  // held low across reset is seen as a fresh press once debounced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_sync   <= 2'b11;
      key_stable <= 1'b1;
      cnt        <= '0;
      key_press  <= 1'b0;
    end else begin
      key_sync  <= {key_sync[0], key};
      key_press <= 1'b0;
      if (key_sync[1] == key_stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        key_stable <= key_sync[1];
        cnt        <= '0;
        // Disagreement implies key_sync[1] is the opposite level, so a stable
        // level of 1 here means this is the 1->0 (press) transition.
        key_press  <= key_stable;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/led_ctrl.sv
// rtl/led_ctrl.sv - key-driven LED mode controller top
//
// Purpose: each debounced key press steps the mode OFF -> ON -> SLOW -> FAST
//          (-> BREATH) -> OFF and drives the LED with the matching waveform.
//          Optional feature macro: LED_CTRL_BREATH_EN adds the BREATH mode with
//          its PWM counter and triangular duty ramp; without it FAST -> OFF.
// Ports:   sys_clk    system clock
//          sys_rst_n  asynchronous active-low reset
//          key        raw push-button, active-low, asynchronous
//          led        LED drive, active-high, registered
//          mode       current mode code, registered
//          key_press  one-cycle pulse per accepted press
module led_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int SLOW_HALF    = 25_000_000,
  parameter int FAST_HALF    = 5_000_000,
  parameter int PWM_BITS     = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              key,
  output logic              led,
  output logic [MODE_W-1:0] mode,
  output logic              key_press
);

  if (DEBOUNCE_CYC < 1 || SLOW_HALF < 1 || FAST_HALF < 1 || PWM_BITS < 1) begin : g_param_check
    $error("led_ctrl: all parameters must be at least 1");
  end

  localparam int HALF_MAX = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
  localparam int BW       = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
  localparam logic [BW-1:0] SLOW_LAST = BW'(SLOW_HALF - 1);
  localparam logic [BW-1:0] FAST_LAST = BW'(FAST_HALF - 1);
  localparam logic [BW-1:0] BLINK_ONE = BW'(1);

  mode_e         mode_q, mode_nxt;
  logic [BW-1:0] blink_cnt_q, blink_cnt_nxt, blink_last;
  logic          phase_q, phase_nxt;
  logic          led_q, led_nxt;
  logic          restart;

  key_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_key_debounce (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .key      (key),
    .key_press(key_press)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_q      <= MODE_OFF;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      led_q       <= 1'b0;
    end else begin
      mode_q      <= mode_nxt;
      blink_cnt_q <= blink_cnt_nxt;
      phase_q     <= phase_nxt;
      led_q       <= led_nxt;
    end
  end

  always_comb begin
    mode_nxt = mode_q;
    case (mode_q)
      MODE_OFF:    if (key_press) mode_nxt = MODE_ON;
      MODE_ON:     if (key_press) mode_nxt = MODE_SLOW;
      MODE_SLOW:   if (key_press) mode_nxt = MODE_FAST;
`ifdef LED_CTRL_BREATH_EN
      MODE_FAST:   if (key_press) mode_nxt = MODE_BREATH;
      MODE_BREATH: if (key_press) mode_nxt = MODE_OFF;
`else
      MODE_FAST:   if (key_press) mode_nxt = MODE_OFF;
`endif
      default:     mode_nxt = MODE_OFF;
    endcase
  end

  // Every press moves to a different mode, so any mode change is an entry and
  // restarts the waveform generators (this also covers a press on a wrap cycle).
  assign restart = (mode_nxt != mode_q);

  always_comb begin
    blink_last    = (mode_q == MODE_SLOW) ? SLOW_LAST : FAST_LAST;
    blink_cnt_nxt = '0;
    phase_nxt     = 1'b1;
    if (!restart && (mode_q == MODE_SLOW || mode_q == MODE_FAST)) begin
      if (blink_cnt_q == blink_last) begin
        blink_cnt_nxt = '0;
        phase_nxt     = ~phase_q;
      end else begin
        blink_cnt_nxt = blink_cnt_q + BLINK_ONE;
        phase_nxt     = phase_q;
      end
    end
  end

`ifdef LED_CTRL_BREATH_EN
  localparam logic [PWM_BITS-1:0] PWM_TOP = '1;
  localparam logic [PWM_BITS-1:0] PWM_ONE = PWM_BITS'(1);

  logic [PWM_BITS-1:0] pwm_q, pwm_nxt, duty_q, duty_nxt;
  logic                dir_up_q, dir_up_nxt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pwm_q    <= '0;
      duty_q   <= '0;
      dir_up_q <= 1'b1;
    end else begin
      pwm_q    <= pwm_nxt;
      duty_q   <= duty_nxt;
      dir_up_q <= dir_up_nxt;
    end
  end

  // Duty moves one step per full PWM period; direction flips as the step
  // reaches the top or bottom value, so each end value lasts one period.
  always_comb begin
    pwm_nxt    = '0;
    duty_nxt   = '0;
    dir_up_nxt = 1'b1;
    if (!restart && mode_q == MODE_BREATH) begin
      pwm_nxt    = pwm_q + PWM_ONE;
      duty_nxt   = duty_q;
      dir_up_nxt = dir_up_q;
      if (pwm_q == PWM_TOP) begin
        if (dir_up_q) begin
          duty_nxt = duty_q + PWM_ONE;
          if (duty_q == PWM_TOP - PWM_ONE) dir_up_nxt = 1'b0;
        end else begin
          duty_nxt = duty_q - PWM_ONE;
          if (duty_q == PWM_ONE) dir_up_nxt = 1'b1;
        end
      end
    end
  end
`endif

  // LED is registered from next-state values so it changes together with mode.
  always_comb begin
    led_nxt = 1'b0;
    case (mode_nxt)
      MODE_ON:              led_nxt = 1'b1;
      MODE_SLOW, MODE_FAST: led_nxt = phase_nxt;
`ifdef LED_CTRL_BREATH_EN
      MODE_BREATH:          led_nxt = (pwm_nxt < duty_nxt);
`endif
      default:              led_nxt = 1'b0;
    endcase
  end

  assign led  = led_q;
  assign mode = mode_q;

endmodule

// File: tb/tb_led_ctrl.sv
// tb/tb_led_ctrl.sv - randomized self-checking bench for led_ctrl
module tb_led_ctrl;

  localparam int DEB  = 4;
  localparam int SLOW = 8;
  localparam int FAST = 2;
  localparam int PB   = 3;
  localparam int PLEN = 1 << PB;
  localparam int PMAX = PLEN - 1;
`ifdef LED_CTRL_BREATH_EN
  localparam int NMODES = 5;
`else
  localparam int NMODES = 4;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       key = 1'b1;
  logic       led, key_press;
  logic [2:0] mode;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   press_due = -1000;
  int   entry = 0;
  int   m_mode = 0;
  logic m_press = 1'b0;
  logic m_led = 1'b0;

  always #5 sys_clk = ~sys_clk;

  led_ctrl #(
    .DEBOUNCE_CYC(DEB),
    .SLOW_HALF   (SLOW),
    .FAST_HALF   (FAST),
    .PWM_BITS    (PB)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key      (key),
    .led      (led),
    .mode     (mode),
    .key_press(key_press)
  );

  // LED level k cycles after entering mode md, straight from the mode rules.
  function automatic logic exp_led(input int md, input int k);
    int p;
    int d;
    p = (k / PLEN) % (2 * PMAX);
    d = (p <= PMAX) ? p : 2 * PMAX - p;
    case (md)
      1:       return 1'b1;
      2:       return ((k / SLOW) % 2) == 0;
      3:       return ((k / FAST) % 2) == 0;
      4:       return (k % PLEN) < d;
      default: return 1'b0;
    endcase
  endfunction

  // Reference model: press_due is the cycle a press pulse is owed, mode steps
  // the cycle after, and the LED follows the time since mode entry.
  always @(posedge sys_clk) begin
    cyc = cyc + 1;
    if (!sys_rst_n) begin
      m_mode = 0; m_press = 1'b0; m_led = 1'b0; entry = cyc; press_due = -1000;
    end else begin
      m_press = (cyc == press_due);
      if (cyc == press_due + 1) begin
        m_mode = (m_mode + 1) % NMODES;
        entry  = cyc;
      end
      m_led = exp_led(m_mode, cyc - entry);
    end
  end

  task automatic key_low(input int hold);
    @(negedge sys_clk); #1;
    key = 1'b0;
    if (hold >= DEB) press_due = cyc + DEB + 2;
    repeat (hold) @(negedge sys_clk);
    #1 key = 1'b1;
  endtask

  task automatic goto_mode(input int target);
    for (int i = 0; i < 2 * NMODES && m_mode != target; i++) begin
      key_low(6);
      repeat (12) @(negedge sys_clk);
    end
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge sys_clk);
      total++;
      if ({key_press, mode, led} !== 5'b0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got press=%b mode=%0d led=%b want 0/0/0", cyc, key_press, mode, led);
      end
      #1 key = 1'($urandom_range(0, 1));
    end
    #1 key = 1'b1;
    @(negedge sys_clk); #1 sys_rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge sys_clk);
      total++;
      if ({key_press, mode, led} !== {m_press, 3'(m_mode), m_led}) begin
        bad++;
        $display("FAIL reset_release cyc=%0d got press=%b mode=%0d led=%b want press=%b mode=%0d led=%b", cyc, key_press, mode, led, m_press, m_mode, m_led);
      end
    end
  endtask

  task automatic test_glitch;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      #($urandom_range(0, 7)) key = 1'b0;
      #($urandom_range(2, 3)) key = 1'b1;
      for (int j = 0; j < 8; j++) begin
        @(negedge sys_clk);
        total++;
        if ({key_press, mode, led} !== {m_press, 3'(m_mode), m_led}) begin
          bad++;
          $display("FAIL glitch_subcycle cyc=%0d got press=%b mode=%0d led=%b want press=%b mode=%0d led=%b", cyc, key_press, mode, led, m_press, m_mode, m_led);
        end
      end
    end
    for (int i = 0; i < 6; i++) begin
      int h;
      h = $urandom_range(1, DEB - 1);
      fork
        key_low(h);
        for (int j = 0; j < h + 10; j++) begin
          @(negedge sys_clk);
          total++;
          if ({key_press, mode, led} !== {m_press, 3'(m_mode), m_led}) begin
            bad++;
            $display("FAIL glitch_short cyc=%0d got press=%b mode=%0d led=%b want press=%b mode=%0d led=%b", cyc, key_press, mode, led, m_press, m_mode, m_led);
          end
        end
      join
    end
  endtask

  task automatic test_press_latency;
    fork
      key_low(20);
      for (int j = 0; j < 32; j++) begin
        @(negedge sys_clk);
        total++;
        if ({key_press, mode, led} !== {m_press, 3'(m_mode), m_led}) begin
          bad++;
          $display("FAIL press_latency cyc=%0d got press=%b mode=%0d led=%b want press=%b mode=%0d led=%b", cyc, key_press, mode, led, m_press, m_mode, m_led);
        end
      end
    join
    total++;
    if (mode !== 3'd1 || led !== 1'b1) begin
      bad++;
      $display("FAIL held_press_mode got mode=%0d led=%b want mode=1 led=1", mode, led);
    end
  endtask

  task automatic test_mode_cycle;
    goto_mode(0);
    for (int i = 0; i < 4; i++) begin
      int h;
      int g;
      h = (i == 0) ? DEB : $urandom_range(DEB, 12);
      g = $urandom_range(20, 40);
      fork
        key_low(h);
        for (int j = 0; j < h + g; j++) begin
          @(negedge sys_clk);
          total++;
          if ({key_press, mode, led} !== {m_press, 3'(m_mode), m_led}) begin
            bad++;
            $display("FAIL mode_cycle cyc=%0d got press=%b mode=%0d led=%b want press=%b mode=%0d led=%b", cyc, key_press, mode, led, m_press, m_mode, m_led);
          end
        end
      join
    end
    total++;
    if (mode !== 3'(4 % NMODES)) begin
      bad++;
      $display("FAIL four_presses got mode=%0d want %0d", mode, 4 % NMODES);
    end
  endtask

`ifdef LED_CTRL_BREATH_EN
  task automatic test_breath;
    goto_mode(4);
    for (int i = 0; i < PLEN && ((cyc - entry) % PLEN) != PLEN - 1; i++) @(negedge sys_clk);
    for (int q = 0; q < 2 * (2 * PMAX) + 2; q++) begin
      int pidx;
      int duty;
      int highs;
      pidx  = ((cyc + 1 - entry) / PLEN) % (2 * PMAX);
      duty  = (pidx <= PMAX) ? pidx : 2 * PMAX - pidx;
      highs = 0;
      for (int r = 0; r < PLEN; r++) begin
        @(negedge sys_clk);
        highs += int'(led);
        total++;
        if ({key_press, mode, led} !== {m_press, 3'(m_mode), m_led}) begin
          bad++;
          $display("FAIL breath_cycle cyc=%0d got press=%b mode=%0d led=%b want press=%b mode=%0d led=%b", cyc, key_press, mode, led, m_press, m_mode, m_led);
        end
      end
      total++;
      if (highs != duty) begin
        bad++;
        $display("FAIL breath_duty period=%0d got high_cycles=%0d want %0d", pidx, highs, duty);
      end
    end
  endtask
`endif

  task automatic test_wrap_press;
    goto_mode(2);
    for (int s = 0; s < 2; s++) begin
      int half;
      half = (s == 0) ? SLOW : FAST;
      // Align so the resulting mode change lands on a blink wrap edge.
      for (int i = 0; i < half && ((cyc - entry) % half) != 0; i++) @(negedge sys_clk);
      fork
        key_low(6);
        for (int j = 0; j < 20; j++) begin
          @(negedge sys_clk);
          total++;
          if ({key_press, mode, led} !== {m_press, 3'(m_mode), m_led}) begin
            bad++;
            $display("FAIL wrap_press cyc=%0d got press=%b mode=%0d led=%b want press=%b mode=%0d led=%b", cyc, key_press, mode, led, m_press, m_mode, m_led);
          end
        end
      join
    end
  endtask

  task automatic test_reset_mid;
    goto_mode(3);
    repeat ($urandom_range(0, 3)) @(negedge sys_clk);
    @(negedge sys_clk); #1 key = 1'b0;
    repeat (2) @(negedge sys_clk);
    #1 sys_rst_n = 1'b0;
    m_mode = 0; m_press = 1'b0; m_led = 1'b0; press_due = -1000;
    #1;
    total++;
    if ({key_press, mode, led} !== 5'b0) begin
      bad++;
      $display("FAIL reset_immediate got press=%b mode=%0d led=%b want 0/0/0", key_press, mode, led);
    end
    repeat (3) @(negedge sys_clk);
    #1 sys_rst_n = 1'b1;
    press_due = cyc + DEB + 2;
    for (int j = 0; j < 26; j++) begin
      @(negedge sys_clk);
      if (j == 16) #1 key = 1'b1;
      total++;
      if ({key_press, mode, led} !== {m_press, 3'(m_mode), m_led}) begin
        bad++;
        $display("FAIL reset_held_key cyc=%0d got press=%b mode=%0d led=%b want press=%b mode=%0d led=%b", cyc, key_press, mode, led, m_press, m_mode, m_led);
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 12; i++) begin
      int h;
      int g;
      h = $urandom_range(1, 30);
      g = $urandom_range(10, 30);
      fork
        key_low(h);
        for (int j = 0; j < h + g; j++) begin
          @(negedge sys_clk);
          total++;
          if ({key_press, mode, led} !== {m_press, 3'(m_mode), m_led}) begin
            bad++;
            $display("FAIL random_press cyc=%0d got press=%b mode=%0d led=%b want press=%b mode=%0d led=%b", cyc, key_press, mode, led, m_press, m_mode, m_led);
          end
        end
      join
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got time_limit want finish test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_glitch;
    test_press_latency;
    test_mode_cycle;
`ifdef LED_CTRL_BREATH_EN
    test_breath;
`endif
    test_wrap_press;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_ctrl.md
# led_ctrl

Key-driven LED mode controller: conditions the raw active-low push-button and sequences the board LED through a fixed set of display modes. It sits between the pad-level key input and the LED pin and replaces direct key-to-LED wiring. Each debounced press advances the mode; the block generates blink and optional breathing waveforms internally.

## Interface

- DEBOUNCE_CYC, 1_000_000, consecutive stable cycles required to accept a key level change (20 ms at 50 MHz)
- SLOW_HALF, 25_000_000, half-period in cycles of slow blink
- FAST_HALF, 5_000_000, half-period in cycles of fast blink
- PWM_BITS, 8, width of breathing PWM counter and duty register

- sys_clk  input  1  single system clock; all logic on rising edge
- sys_rst_n  input  1  asynchronous, active-low reset
- key  input  1  raw push-button, active-low (idle high), asynchronous to sys_clk
- led  output  1  LED drive, active-high, registered
- mode  output  3  current mode code, registered
- key_press  output  1  one-cycle pulse per accepted press

## Operation

- Synchronizer: 2 flops on key, both reset to 1.
- Debounce: key_stable (reset 1); counter clears whenever key_sync == key_stable, else increments; on reaching DEBOUNCE_CYC-1, key_stable takes key_sync and counter clears. Glitches shorter than DEBOUNCE_CYC cycles are ignored.
- key_press = 1 for exactly one cycle when key_stable goes 1->0; release (0->1) produces no pulse.
- Mode FSM, advanced only on key_press: OFF(0) -> ON(1) -> SLOW(2) -> FAST(3) -> OFF; with breathing compiled in, FAST -> BREATH(4) -> OFF.
- OFF: led=0. ON: led=1.
- SLOW/FAST: blink counter counts 0..HALF-1, wraps, toggles phase at HALF-1; led = phase. On entry to a mode, counter=0 and phase=1 (led on first).
- BREATH: free-running PWM_BITS counter; duty steps +1 per PWM period up to 2^PWM_BITS-1, then -1 down to 0, repeating; led = (pwm_cnt < duty). Entry clears pwm_cnt, duty=0, direction=up.
- Codes 5..7 unreachable; if ever held, next cycle forces OFF.

## Timing

- Reset values: led=0, mode=0 (OFF), key_press=0, all counters 0, phase=1.
- Press latency: raw key falling edge -> key_press high after DEBOUNCE_CYC+2 cycles (2 sync + debounce).
- mode and led updated in the cycle after key_press (one registered stage).
- Key held low indefinitely: one pulse only; next press needs release accepted first.
- Press arriving on a blink wrap cycle: mode change wins; counters restart per entry rule.
- Reset asserted mid-debounce or mid-blink: all state cleared immediately; a key still held low at release of reset produces a press once debounced (stable resets to 1).

## Configuration

- LED_CTRL_BREATH_EN defined: BREATH mode, PWM counter and duty ramp present; FAST -> BREATH -> OFF.
- Undefined: no PWM logic; FAST -> OFF; mode code 4 never produced.

## Structure

- Package led_ctrl_pkg: mode enum (MODE_OFF, MODE_ON, MODE_SLOW, MODE_FAST, MODE_BREATH) on 3 bits, MODE_W constant.
- Sub-module key_debounce (synchronizer, debounce counter, press pulse), parameter DEBOUNCE_CYC; led_ctrl instantiates it plus the mode FSM and waveform generators.

## Test plan

Use DEBOUNCE_CYC=4, SLOW_HALF=8, FAST_HALF=2, PWM_BITS=3.
- Reset held, key toggling -> led=0, mode=0, key_press=0; after release with key high, outputs unchanged.
- Key low pulses of 2 ns / 3 ns (sub-cycle) and 3-cycle lows -> no key_press, mode stays 0.
- Key low held 20 cycles -> exactly one key_press, 6 cycles after edge; mode=1, led=1 next cycle.
- Four clean presses -> mode 1,2,3 then 0 (macro off) or 4 (macro on); in SLOW, led high 8 cycles, low 8; in FAST, 2/2.
- Macro on, BREATH: duty ramps 0..7..0; led high count per 8-cycle period equals duty.
- Press landing on blink wrap cycle and reset asserted mid-FAST -> mode advances cleanly; reset returns led=0, mode=0 immediately.
